conv_out_buffer: RTL and testbench

- Downstream neighbour of conv2d. Captures conv2d's write stream (WriteEnable / WriteAddress / d_out) into an internal IMG_W x IMG_H frame RAM.
- When conv2d raises ready, the block drains the frame in raster order over a valid/ready stream.
- Sink is a display/UART/DMA stage. The block replaces the behavioural mem_out array with synthesizable storage and a flow-controlled readout.

---
 rtl/conv_out_buffer.sv | 161 ++++++++++++++++
 tb/tb_conv_out_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_buffer.sv
// Frame buffer behind conv2d: captures the write stream into a RAM
// and drains it in raster order over a valid/ready stream.
module conv_out_buffer #(
  parameter int IMG_W = 50,
  parameter int IMG_H = 50,
  parameter int DW    = 12,
  parameter int AW    = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          conv_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          done,
  output logic          busy,
  output logic          err
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int PW    = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic          cr_q;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          issued_q, issued_d;
  logic          s1_v_q, s1_v_d;
  logic          s1_last_q, s1_last_d;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          err_q, err_d;

  logic [DW-1:0] mem [DEPTH];

  logic rise;
  logic wr_ok;
  logic wr_bad;
  logic rd_en;
  logic load;
  logic addr_ok;

  always_comb begin
    state_d   = state_q;
    rptr_d    = rptr_q;
    issued_d  = issued_q;
    s1_v_d    = s1_v_q;
    s1_last_d = s1_last_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    err_d     = err_q;
    wr_ok     = 1'b0;
    wr_bad    = 1'b0;
    rd_en     = 1'b0;
    load      = 1'b0;
    rise      = conv_ready & ~cr_q;
    addr_ok   = wr_addr < DEPTH_A;

    unique case (state_q)
      IDLE: begin
        wr_ok  = wr_en & addr_ok;
        wr_bad = wr_en & ~addr_ok;
        if (rise) begin
          state_d   = DRAIN;
          rptr_d    = '0;
          issued_d  = 1'b0;
          s1_v_d    = 1'b0;
          s1_last_d = 1'b0;
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      DRAIN: begin
        wr_bad = wr_en;
        // Output register refills whenever empty or being consumed;
        // the RAM read register acts as the skid stage behind it.
        load  = ~m_valid_q | m_ready;
        rd_en = ~issued_q & (~s1_v_q | load);
        if (load) begin
          m_valid_d = s1_v_q;
          m_last_d  = s1_v_q & s1_last_q;
          if (s1_v_q) m_data_d = rd_data_q;
          s1_v_d = 1'b0;
        end
        if (rd_en) begin
          s1_v_d    = 1'b1;
          s1_last_d = rptr_q == LAST;
          if (rptr_q == LAST) issued_d = 1'b1;
          else rptr_d = rptr_q + 1'b1;
        end
        if (m_valid_q & m_ready & m_last_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        wr_ok     = wr_en & addr_ok;
        wr_bad    = wr_en & ~addr_ok;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[PW-1:0]] <= wr_data;
    if (rd_en) rd_data_q <= mem[rptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cr_q      <= 1'b0;
      rptr_q    <= '0;
      issued_q  <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cr_q      <= conv_ready;
      rptr_q    <= rptr_d;
      issued_q  <= issued_d;
      s1_v_q    <= s1_v_d;
      s1_last_q <= s1_last_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign err     = err_q;
  assign busy    = state_q == DRAIN;
  assign done    = state_q == DONE;

endmodule

// File: tb/tb_conv_out_buffer.sv
// Bench for conv_out_buffer: frame model array, randomized write order
// and sink backpressure, directed fault scenarios.
module tb_conv_out_buffer;

  localparam int DEPTH = 2500;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        conv_ready;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        done;
  logic        busy;
  logic        err;

  conv_out_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .conv_ready (conv_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [11:0] model [DEPTH];
  logic        err_exp = 1'b0;
  int          perm [DEPTH];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = 17'(a);
    wr_data = d;
    if (a < DEPTH) model[a] = d;
    else err_exp = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Sink side: pulse conv_ready, consume beats, compare with the model.
  task automatic drain(input int pct, input int wr_at, input int rst_at);
    int k = 0;
    int cyc = 0;
    int first_v = -1;
    int fc = 0;
    int lc = 0;
    bit pend = 0;
    bit inj = 0;
    logic [11:0] pd = '0;
    logic pl = 1'b0;
    conv_ready = 1'b1;
    @(negedge clk);
    conv_ready = 1'b0;
    cyc = 1;
    chk("busy_on_entry", 32'(busy), 32'd1);
    while (k < DEPTH && cyc < 30000) begin
      wr_en   = 1'b0;
      m_ready = ($urandom_range(99) < pct);
      if (pend) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(pd));
        chk("hold_last", 32'(m_last), 32'(pl));
      end
      if (m_valid && first_v < 0) begin
        first_v = cyc;
        chk("first_valid_lat", 32'(cyc), 32'd3);
      end
      if (m_valid && m_ready) begin
        chk("beat_data", 32'(m_data), 32'(model[k]));
        chk("beat_last", 32'(m_last), 32'(k == DEPTH - 1));
        if (k == 0) fc = cyc;
        lc = cyc;
        k++;
      end
      pend = m_valid && !m_ready;
      pd   = m_data;
      pl   = m_last;
      if (k == wr_at && !inj) begin
        inj     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 17'd2000;
        wr_data = 12'h123;
        err_exp = 1'b1;
      end
      if (k == rst_at) begin
        m_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        err_exp = 1'b0;
        chk("rst_mid_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_last", 32'(m_last), 32'd0);
        chk("rst_mid_data", 32'(m_data), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(m_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    wr_en   = 1'b0;
    m_ready = 1'b0;
    chk("beat_count", 32'(k), 32'(DEPTH));
    if (pct == 100) chk("throughput", 32'(lc - fc), 32'(DEPTH - 1));
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_valid", 32'(m_valid), 32'd0);
    chk("err_state", 32'(err), 32'(err_exp));
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    conv_ready = 1'b0;
    m_ready    = 1'b0;
    #3;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_valid", 32'(m_valid), 32'd0);
    chk("idle_busy0", 32'(busy), 32'd0);

    for (int i = 0; i < DEPTH; i++) perm[i] = i;
    for (int i = DEPTH - 1; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(i);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < DEPTH; i++) begin
      int a;
      a = perm[i];
      wr(a, 12'(a));
    end
    chk("err_after_frame", 32'(err), 32'd0);

    drain(100, -1, -1);
    drain(30, -1, -1);

    wr(2500, 12'hFFF);
    chk("err_illegal", 32'(err), 32'd1);
    drain(100, -1, -1);

    drain(100, 100, -1);
    chk("err_drain_wr", 32'(err), 32'd1);
    chk("model_2000", 32'(model[2000]), 32'h7D0);

    drain(100, -1, 1000);
    chk("err_cleared", 32'(err), 32'd0);
    drain(100, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
